// File: rtl/cpu_run_ctrl.sv
// Run sequencer for the 9-bit CPU: holds it in reset, optionally preloads data
// memory from a byte stream, runs it until done or timeout, and reports status.
module cpu_run_ctrl #(
    parameter int MAX_CYCLES = 4096,
    parameter int CNT_W      = 16,
    parameter int RST_CYC    = 2
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic             preload,
    input  logic             abort,
    input  logic             ld_valid,
    input  logic [7:0]       ld_data,
    input  logic             ld_last,
    output logic             ld_ready,
    output logic             dm_we,
    output logic [7:0]       dm_addr,
    output logic [7:0]       dm_wdata,
    output logic             cpu_reset,
    input  logic             cpu_done,
    output logic             busy,
    output logic [1:0]       status,
    output logic             status_valid,
    output logic [CNT_W-1:0] cycles
);

    localparam logic [2:0] IDLE   = 3'd0;
    localparam logic [2:0] LOAD   = 3'd1;
    localparam logic [2:0] RST    = 3'd2;
    localparam logic [2:0] FINISH = 3'd3;
    localparam logic [2:0] RUN    = 3'd4;

    localparam logic [1:0] ST_OK      = 2'b01;
    localparam logic [1:0] ST_TIMEOUT = 2'b10;
    localparam logic [1:0] ST_ABORT   = 2'b11;

    localparam int RW = (RST_CYC > 1) ? $clog2(RST_CYC) : 1;

    logic [2:0]    state;
    logic [2:0]    next_state;
    logic [1:0]    fin_code;
    logic [8:0]    addr_cnt;
    logic [RW-1:0] rst_cnt;
    logic          accept;
    logic          done_q;
    logic          timeout;

    // Bit 8 of the address counter marks a full 256-byte image.
    assign ld_ready = (state == LOAD) && !addr_cnt[8];
    assign accept   = ld_valid && ld_ready;
    // The first RUN cycle is the only one where cycles is still zero.
    assign done_q   = cpu_done && (cycles != '0);
    assign timeout  = (cycles == CNT_W'(MAX_CYCLES - 1));

    always_comb begin
        next_state = state;
        fin_code   = 2'b00;
        case (state)
            IDLE: begin
                if (start) next_state = preload ? LOAD : RST;
            end
            LOAD: begin
                if (abort) begin
                    next_state = FINISH;
                    fin_code   = ST_ABORT;
                end else if (accept && (ld_last || addr_cnt[7:0] == 8'hFF)) begin
                    next_state = RST;
                end
            end
            RST: begin
                if (abort) begin
                    next_state = FINISH;
                    fin_code   = ST_ABORT;
                end else if (rst_cnt == RW'(RST_CYC - 1)) begin
                    next_state = RUN;
                end
            end
            RUN: begin
                if (abort) begin
                    next_state = FINISH;
                    fin_code   = ST_ABORT;
                end else if (done_q) begin
                    next_state = FINISH;
                    fin_code   = ST_OK;
                end else if (timeout) begin
                    next_state = FINISH;
                    fin_code   = ST_TIMEOUT;
                end
            end
            FINISH:  next_state = IDLE;
            default: next_state = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state        <= IDLE;
            addr_cnt     <= '0;
            rst_cnt      <= '0;
            cpu_reset    <= 1'b1;
            busy         <= 1'b0;
            dm_we        <= 1'b0;
            dm_addr      <= '0;
            dm_wdata     <= '0;
            status       <= '0;
            status_valid <= 1'b0;
            cycles       <= '0;
        end else begin
            state        <= next_state;
            busy         <= (next_state != IDLE);
            cpu_reset    <= (next_state != RUN);
            status_valid <= (next_state == FINISH);
            dm_we        <= accept;

            if (accept) begin
                dm_addr  <= addr_cnt[7:0];
                dm_wdata <= ld_data;
                addr_cnt <= addr_cnt + 9'd1;
            end

            if (state == IDLE && start) begin
                status   <= '0;
                cycles   <= '0;
                addr_cnt <= '0;
            end

            if (next_state == FINISH && state != FINISH) status <= fin_code;

            rst_cnt <= (state == RST) ? rst_cnt + RW'(1) : '0;

            // Cycles freezes in the cycle that decides the outcome.
            if (state == RUN && next_state == RUN) cycles <= cycles + CNT_W'(1);
        end
    end

endmodule

// File: tb/tb_cpu_run_ctrl.sv
// Directed self-checking bench for cpu_run_ctrl; a second instance with a short
// cycle budget covers the timeout path.
module tb_cpu_run_ctrl;

    logic        clk = 1'b0;
    logic        reset, start, preload, abort, ld_valid, ld_last, cpu_done;
    logic [7:0]  ld_data;

    logic        ld_ready, dm_we, cpu_reset, busy, status_valid;
    logic [7:0]  dm_addr, dm_wdata;
    logic [1:0]  status;
    logic [15:0] cycles;

    logic        to_ld_ready, to_dm_we, to_cpu_reset, to_busy, to_status_valid;
    logic [7:0]  to_dm_addr, to_dm_wdata;
    logic [1:0]  to_status;
    logic [15:0] to_cycles;

    int vectors = 0;
    int miscompares = 0;

    always #5 clk = ~clk;

    cpu_run_ctrl #(.MAX_CYCLES(4096), .CNT_W(16), .RST_CYC(2)) dut (
        .clk(clk), .reset(reset), .start(start), .preload(preload), .abort(abort),
        .ld_valid(ld_valid), .ld_data(ld_data), .ld_last(ld_last), .ld_ready(ld_ready),
        .dm_we(dm_we), .dm_addr(dm_addr), .dm_wdata(dm_wdata), .cpu_reset(cpu_reset),
        .cpu_done(cpu_done), .busy(busy), .status(status), .status_valid(status_valid),
        .cycles(cycles)
    );

    cpu_run_ctrl #(.MAX_CYCLES(8), .CNT_W(16), .RST_CYC(2)) dut_to (
        .clk(clk), .reset(reset), .start(start), .preload(preload), .abort(abort),
        .ld_valid(ld_valid), .ld_data(ld_data), .ld_last(ld_last), .ld_ready(to_ld_ready),
        .dm_we(to_dm_we), .dm_addr(to_dm_addr), .dm_wdata(to_dm_wdata),
        .cpu_reset(to_cpu_reset), .cpu_done(cpu_done), .busy(to_busy), .status(to_status),
        .status_valid(to_status_valid), .cycles(to_cycles)
    );

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic test_power_on();
        reset = 1'b1; start = 0; preload = 0; abort = 0;
        ld_valid = 0; ld_last = 0; ld_data = 8'h00; cpu_done = 0;
        step();
        step();
        vectors++; if (cpu_reset !== 1'b1) begin miscompares++; $display("FAIL por_cpu_reset: got %b want 1", cpu_reset); end
        vectors++; if ({busy, ld_ready, dm_we, status_valid} !== 4'b0000) begin miscompares++; $display("FAIL por_flags: got %b want 0000", {busy, ld_ready, dm_we, status_valid}); end
        vectors++; if ({dm_addr, dm_wdata, status, cycles} !== 34'd0) begin miscompares++; $display("FAIL por_data: got %h want 0", {dm_addr, dm_wdata, status, cycles}); end
        reset = 1'b0;
        step();
    endtask

    task automatic test_preload();
        start = 1; preload = 1;
        step();
        start = 0; preload = 0;
        vectors++; if ({busy, ld_ready, cpu_reset} !== 3'b111) begin miscompares++; $display("FAIL pre_load_entry: got %b want 111", {busy, ld_ready, cpu_reset}); end
        ld_valid = 1; ld_data = 8'h11; ld_last = 0;
        step();
        vectors++; if ({dm_we, dm_addr, dm_wdata} !== {1'b1, 8'h00, 8'h11}) begin miscompares++; $display("FAIL pre_wr0: got %h want 10011", {dm_we, dm_addr, dm_wdata}); end
        ld_data = 8'h22;
        step();
        vectors++; if ({dm_we, dm_addr, dm_wdata} !== {1'b1, 8'h01, 8'h22}) begin miscompares++; $display("FAIL pre_wr1: got %h want 10122", {dm_we, dm_addr, dm_wdata}); end
        ld_data = 8'h33; ld_last = 1;
        step();
        ld_valid = 0; ld_last = 0;
        vectors++; if ({dm_we, dm_addr, dm_wdata} !== {1'b1, 8'h02, 8'h33}) begin miscompares++; $display("FAIL pre_wr2: got %h want 10233", {dm_we, dm_addr, dm_wdata}); end
        vectors++; if ({ld_ready, cpu_reset} !== 2'b01) begin miscompares++; $display("FAIL pre_rst1: got %b want 01", {ld_ready, cpu_reset}); end
        step();
        vectors++; if ({dm_we, cpu_reset} !== 2'b01) begin miscompares++; $display("FAIL pre_rst2: got %b want 01", {dm_we, cpu_reset}); end
        step();
        vectors++; if ({busy, cpu_reset} !== 2'b10) begin miscompares++; $display("FAIL pre_run: got %b want 10", {busy, cpu_reset}); end
        abort = 1;
        step();
        abort = 0;
        vectors++; if ({status_valid, status} !== 3'b111) begin miscompares++; $display("FAIL pre_abort: got %b want 111", {status_valid, status}); end
        step();
    endtask

    task automatic test_done_run();
        start = 1; preload = 0;
        step();
        start = 0;
        vectors++; if ({busy, cpu_reset} !== 2'b11) begin miscompares++; $display("FAIL done_rst1: got %b want 11", {busy, cpu_reset}); end
        step();
        vectors++; if (cpu_reset !== 1'b1) begin miscompares++; $display("FAIL done_rst2: got %b want 1", cpu_reset); end
        step();
        vectors++; if ({cpu_reset, cycles} !== {1'b0, 16'd0}) begin miscompares++; $display("FAIL done_run0: got %h want 0", {cpu_reset, cycles}); end
        cpu_done = 1;
        ld_valid = 1;
        step();
        cpu_done = 0;
        vectors++; if ({busy, status_valid, cycles} !== {2'b10, 16'd1}) begin miscompares++; $display("FAIL done_first_ignored: got %h want 20001", {busy, status_valid, cycles}); end
        vectors++; if ({ld_ready, dm_we} !== 2'b00) begin miscompares++; $display("FAIL done_ld_ignored: got %b want 00", {ld_ready, dm_we}); end
        ld_valid = 0;
        for (int i = 0; i < 8; i++) step();
        vectors++; if (cycles !== 16'd9) begin miscompares++; $display("FAIL done_cyc9: got %0d want 9", cycles); end
        cpu_done = 1;
        step();
        cpu_done = 0;
        vectors++; if ({status_valid, status, cycles, cpu_reset, busy} !== {3'b101, 16'd9, 2'b11}) begin miscompares++; $display("FAIL done_finish: got %h want %h", {status_valid, status, cycles, cpu_reset, busy}, {3'b101, 16'd9, 2'b11}); end
        step();
        vectors++; if ({status_valid, busy, status, cycles} !== {4'b0001, 16'd9}) begin miscompares++; $display("FAIL done_idle: got %h want %h", {status_valid, busy, status, cycles}, {4'b0001, 16'd9}); end
    endtask

    task automatic test_timeout();
        start = 1; preload = 0;
        step();
        start = 0;
        step();
        step();
        vectors++; if ({to_cpu_reset, to_cycles} !== {1'b0, 16'd0}) begin miscompares++; $display("FAIL to_run0: got %h want 0", {to_cpu_reset, to_cycles}); end
        for (int i = 0; i < 7; i++) step();
        vectors++; if ({to_busy, to_cpu_reset, to_cycles} !== {2'b10, 16'd7}) begin miscompares++; $display("FAIL to_last_run: got %h want %h", {to_busy, to_cpu_reset, to_cycles}, {2'b10, 16'd7}); end
        step();
        vectors++; if ({to_status_valid, to_status, to_cycles, to_cpu_reset} !== {3'b110, 16'd7, 1'b1}) begin miscompares++; $display("FAIL to_finish: got %h want %h", {to_status_valid, to_status, to_cycles, to_cpu_reset}, {3'b110, 16'd7, 1'b1}); end
        abort = 1;
        step();
        abort = 0;
        vectors++; if ({to_busy, to_status, to_cycles} !== {3'b010, 16'd7}) begin miscompares++; $display("FAIL to_hold: got %h want %h", {to_busy, to_status, to_cycles}, {3'b010, 16'd7}); end
        step();
    endtask

    task automatic test_full_preload();
        int offered;
        int writes;
        offered = 0;
        writes = 0;
        start = 1; preload = 1;
        step();
        start = 0; preload = 0;
        ld_valid = 1; ld_last = 0;
        for (int c = 0; c < 300; c++) begin
            ld_data = 8'(offered) ^ 8'hA5;
            if (ld_ready) offered++;
            step();
            if (dm_we) begin
                vectors++;
                if ({dm_addr, dm_wdata} !== {8'(writes), 8'(writes) ^ 8'hA5}) begin
                    miscompares++;
                    $display("FAIL full_wr%0d: got %h want %h", writes, {dm_addr, dm_wdata}, {8'(writes), 8'(writes) ^ 8'hA5});
                end
                writes++;
            end
        end
        vectors++; if (writes != 256) begin miscompares++; $display("FAIL full_count: got %0d want 256", writes); end
        vectors++; if (ld_ready !== 1'b0) begin miscompares++; $display("FAIL full_ready_low: got %b want 0", ld_ready); end
        ld_valid = 0;
        abort = 1;
        step();
        abort = 0;
        step();
    endtask

    task automatic test_priority();
        start = 1; preload = 0;
        step();
        start = 0;
        step();
        step();
        step();
        abort = 1; cpu_done = 1;
        step();
        abort = 0; cpu_done = 0;
        vectors++; if ({status_valid, status} !== 3'b111) begin miscompares++; $display("FAIL prio_abort_over_done: got %b want 111", {status_valid, status}); end
        start = 1;
        step();
        start = 0;
        step();
        vectors++; if ({busy, status} !== 3'b011) begin miscompares++; $display("FAIL prio_start_in_finish: got %b want 011", {busy, status}); end
    endtask

    task automatic test_reset();
        start = 1; preload = 0;
        step();
        start = 0;
        for (int i = 0; i < 5; i++) step();
        vectors++; if ({cpu_reset, cycles} !== {1'b0, 16'd3}) begin miscompares++; $display("FAIL rst_pre_run: got %h want 3", {cpu_reset, cycles}); end
        reset = 1;
        for (int i = 0; i < 3; i++) step();
        vectors++; if (cpu_reset !== 1'b1) begin miscompares++; $display("FAIL rst_cpu_reset: got %b want 1", cpu_reset); end
        vectors++; if ({busy, ld_ready, dm_we, status_valid, dm_addr, dm_wdata, status, cycles} !== 38'd0) begin miscompares++; $display("FAIL rst_outputs: got %h want 0", {busy, ld_ready, dm_we, status_valid, dm_addr, dm_wdata, status, cycles}); end
        reset = 0;
        step();
        step();
        vectors++; if ({busy, cpu_reset} !== 2'b01) begin miscompares++; $display("FAIL rst_idle: got %b want 01", {busy, cpu_reset}); end
    endtask

    initial begin
        test_power_on();
        test_preload();
        test_done_run();
        test_timeout();
        test_full_preload();
        test_priority();
        test_reset();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
